// File: rtl/mem_arbiter_if.sv
// Shared-port bundle between the IF/MEM requesters, the arbiter and the MMU.
// The arbiter takes the slave view and the requester/MMU side takes the master view.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_ready;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_bytemode;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        mmu_read;
  logic        mmu_write;
  logic [31:0] mmu_addr;
  logic [31:0] mmu_wdata;
  logic        mmu_bytemode;
  logic [31:0] mmu_rdata;

  modport slave (
    input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata, mem_bytemode, mmu_rdata,
    output if_data, if_ready, mem_rdata, mem_ready, stall,
           mmu_read, mmu_write, mmu_addr, mmu_wdata, mmu_bytemode
  );

  modport master (
    output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata, mem_bytemode, mmu_rdata,
    input  if_data, if_ready, mem_rdata, mem_ready, stall,
           mmu_read, mmu_write, mmu_addr, mmu_wdata, mmu_bytemode
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single MMU port between instruction fetch and data access,
// holding each access for WAIT_CYCLES cycles and returning a one-cycle ready pulse.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2  // legal range 1..15
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        src_mem;
  logic        mmu_read_q;
  logic        mmu_write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        bytemode_q;
  logic [31:0] if_data_q;
  logic [31:0] mem_rdata_q;
  logic        if_ready_q;
  logic        mem_ready_q;

  // The MMU strobes are registered, so they fall with reset immediately and are
  // never dependent on requester inputs that change mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      src_mem     <= 1'b0;
      mmu_read_q  <= 1'b0;
      mmu_write_q <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      bytemode_q  <= 1'b0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state)
        IDLE: begin
          // Data wins over fetch; read+write together is taken as a write.
          if (bus.mem_read || bus.mem_write) begin
            src_mem     <= 1'b1;
            addr_q      <= bus.mem_addr;
            wdata_q     <= bus.mem_wdata;
            bytemode_q  <= bus.mem_bytemode;
            mmu_read_q  <= ~bus.mem_write;
            mmu_write_q <= bus.mem_write;
            wait_cnt    <= CNT_INIT;
            state       <= ACCESS;
          end else if (bus.if_req) begin
            src_mem     <= 1'b0;
            addr_q      <= bus.if_addr;
            wdata_q     <= 32'h0;
            bytemode_q  <= 1'b0;
            mmu_read_q  <= 1'b1;
            mmu_write_q <= 1'b0;
            wait_cnt    <= CNT_INIT;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            mmu_read_q  <= 1'b0;
            mmu_write_q <= 1'b0;
            if (!mmu_write_q) begin
              if (src_mem) mem_rdata_q <= bus.mmu_rdata;
              else         if_data_q   <= bus.mmu_rdata;
            end
            if (src_mem) mem_ready_q <= 1'b1;
            else         if_ready_q  <= 1'b1;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mmu_read     = mmu_read_q;
  assign bus.mmu_write    = mmu_write_q;
  assign bus.mmu_addr     = addr_q;
  assign bus.mmu_wdata    = wdata_q;
  assign bus.mmu_bytemode = bytemode_q;
  assign bus.if_data      = if_data_q;
  assign bus.if_ready     = if_ready_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.mem_ready    = mem_ready_q;

  // The ready pulse itself releases the stall in the RESP cycle.
  assign bus.stall = rst_n & (((bus.mem_read | bus.mem_write) & ~mem_ready_q) |
                              (bus.if_req & ~if_ready_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for the main
// arbitration scenarios plus hand-written reset and WAIT_CYCLES=1 sequences.
module tb_mem_arbiter;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_bytemode;
    logic [31:0] mmu_rdata;
    logic        e_mmu_read;
    logic        e_mmu_write;
    logic [31:0] e_mmu_addr;
    logic        chk_side;
    logic [31:0] e_mmu_wdata;
    logic        e_mmu_bytemode;
    logic        e_if_ready;
    logic [31:0] e_if_data;
    logic        e_mem_ready;
    logic [31:0] e_mem_rdata;
    logic        e_stall;
  } vec_t;

  localparam int NVEC = 24;

  localparam logic [31:0] Z    = 32'h0000_0000;
  localparam logic [31:0] A_F0 = 32'h8000_0000;
  localparam logic [31:0] A_F1 = 32'h8000_0100;
  localparam logic [31:0] A_S  = 32'h8040_0007;
  localparam logic [31:0] A_D0 = 32'h8000_0010;
  localparam logic [31:0] A_D1 = 32'h8000_0020;
  localparam logic [31:0] A_W  = 32'h8000_0030;
  localparam logic [31:0] A_R  = 32'h8000_0040;
  localparam logic [31:0] AB   = 32'h0000_00AB;
  localparam logic [31:0] W    = 32'h1234_5678;
  localparam logic [31:0] I0   = 32'h2401_0001;
  localparam logic [31:0] I1   = 32'h1111_2222;
  localparam logic [31:0] DB   = 32'hDEAD_BEEF;
  localparam logic [31:0] FF   = 32'hFFFF_FFFF;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  vec_t vecs [NVEC];

  mem_arbiter_if bus ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.if_req       = v.if_req;
    bus.if_addr      = v.if_addr;
    bus.mem_read     = v.mem_read;
    bus.mem_write    = v.mem_write;
    bus.mem_addr     = v.mem_addr;
    bus.mem_wdata    = v.mem_wdata;
    bus.mem_bytemode = v.mem_bytemode;
    bus.mmu_rdata    = v.mmu_rdata;
  endtask

  initial begin
    int k;
    int reads;
    logic seen;

    errors = 0;
    checks = 0;

    // Columns: stimulus (if_req..mmu_rdata) | expected outputs in the same cycle.
    // Single fetch
    vecs[0]  = '{1'b1, A_F0, 1'b0, 1'b0, Z, Z, 1'b0, Z,   1'b0, 1'b0, Z,    1'b0, Z, 1'b0, 1'b0, Z,  1'b0, Z,  1'b1};
    vecs[1]  = '{1'b1, A_F0, 1'b0, 1'b0, Z, Z, 1'b0, I0,  1'b1, 1'b0, A_F0, 1'b0, Z, 1'b0, 1'b0, Z,  1'b0, Z,  1'b1};
    vecs[2]  = '{1'b1, A_F0, 1'b0, 1'b0, Z, Z, 1'b0, I0,  1'b1, 1'b0, A_F0, 1'b0, Z, 1'b0, 1'b0, Z,  1'b0, Z,  1'b1};
    vecs[3]  = '{1'b1, A_F0, 1'b0, 1'b0, Z, Z, 1'b0, Z,   1'b0, 1'b0, A_F0, 1'b0, Z, 1'b0, 1'b1, I0, 1'b0, Z,  1'b0};
    vecs[4]  = '{1'b0, Z,    1'b0, 1'b0, Z, Z, 1'b0, Z,   1'b0, 1'b0, A_F0, 1'b0, Z, 1'b0, 1'b0, I0, 1'b0, Z,  1'b0};
    // Byte store
    vecs[5]  = '{1'b0, Z, 1'b0, 1'b1, A_S, AB, 1'b1, Z,   1'b0, 1'b0, A_F0, 1'b0, Z,  1'b0, 1'b0, I0, 1'b0, Z,  1'b1};
    vecs[6]  = '{1'b0, Z, 1'b0, 1'b1, A_S, AB, 1'b1, Z,   1'b0, 1'b1, A_S,  1'b1, AB, 1'b1, 1'b0, I0, 1'b0, Z,  1'b1};
    vecs[7]  = '{1'b0, Z, 1'b0, 1'b1, A_S, AB, 1'b1, Z,   1'b0, 1'b1, A_S,  1'b1, AB, 1'b1, 1'b0, I0, 1'b0, Z,  1'b1};
    vecs[8]  = '{1'b0, Z, 1'b0, 1'b1, A_S, AB, 1'b1, Z,   1'b0, 1'b0, A_S,  1'b0, Z,  1'b0, 1'b0, I0, 1'b1, Z,  1'b0};
    vecs[9]  = '{1'b0, Z, 1'b0, 1'b0, Z,   Z,  1'b0, Z,   1'b0, 1'b0, A_S,  1'b0, Z,  1'b0, 1'b0, I0, 1'b0, Z,  1'b0};
    // Contention, with mem_addr changing mid-access
    vecs[10] = '{1'b1, A_F1, 1'b1, 1'b0, A_D0, Z, 1'b0, Z,  1'b0, 1'b0, A_S,  1'b0, Z, 1'b0, 1'b0, I0, 1'b0, Z,  1'b1};
    vecs[11] = '{1'b1, A_F1, 1'b1, 1'b0, A_D0, Z, 1'b0, DB, 1'b1, 1'b0, A_D0, 1'b1, Z, 1'b0, 1'b0, I0, 1'b0, Z,  1'b1};
    vecs[12] = '{1'b1, A_F1, 1'b1, 1'b0, A_D1, Z, 1'b0, DB, 1'b1, 1'b0, A_D0, 1'b1, Z, 1'b0, 1'b0, I0, 1'b0, Z,  1'b1};
    vecs[13] = '{1'b1, A_F1, 1'b1, 1'b0, A_D1, Z, 1'b0, Z,  1'b0, 1'b0, A_D0, 1'b0, Z, 1'b0, 1'b0, I0, 1'b1, DB, 1'b1};
    vecs[14] = '{1'b1, A_F1, 1'b0, 1'b0, Z,    Z, 1'b0, Z,  1'b0, 1'b0, A_D0, 1'b0, Z, 1'b0, 1'b0, I0, 1'b0, DB, 1'b1};
    vecs[15] = '{1'b1, A_F1, 1'b0, 1'b0, Z,    Z, 1'b0, I1, 1'b1, 1'b0, A_F1, 1'b0, Z, 1'b0, 1'b0, I0, 1'b0, DB, 1'b1};
    vecs[16] = '{1'b1, A_F1, 1'b0, 1'b0, Z,    Z, 1'b0, I1, 1'b1, 1'b0, A_F1, 1'b0, Z, 1'b0, 1'b0, I0, 1'b0, DB, 1'b1};
    vecs[17] = '{1'b1, A_F1, 1'b0, 1'b0, Z,    Z, 1'b0, Z,  1'b0, 1'b0, A_F1, 1'b0, Z, 1'b0, 1'b1, I1, 1'b0, DB, 1'b0};
    vecs[18] = '{1'b0, Z,    1'b0, 1'b0, Z,    Z, 1'b0, Z,  1'b0, 1'b0, A_F1, 1'b0, Z, 1'b0, 1'b0, I1, 1'b0, DB, 1'b0};
    // Read+write together acts as a word store; mem_rdata must not change
    vecs[19] = '{1'b0, Z, 1'b1, 1'b1, A_W, W, 1'b0, FF,  1'b0, 1'b0, A_F1, 1'b0, Z, 1'b0, 1'b0, I1, 1'b0, DB, 1'b1};
    vecs[20] = '{1'b0, Z, 1'b1, 1'b1, A_W, W, 1'b0, FF,  1'b0, 1'b1, A_W,  1'b1, W, 1'b0, 1'b0, I1, 1'b0, DB, 1'b1};
    vecs[21] = '{1'b0, Z, 1'b1, 1'b1, A_W, W, 1'b0, FF,  1'b0, 1'b1, A_W,  1'b1, W, 1'b0, 1'b0, I1, 1'b0, DB, 1'b1};
    vecs[22] = '{1'b0, Z, 1'b1, 1'b1, A_W, W, 1'b0, FF,  1'b0, 1'b0, A_W,  1'b0, Z, 1'b0, 1'b0, I1, 1'b1, DB, 1'b0};
    vecs[23] = '{1'b0, Z, 1'b0, 1'b0, Z,   Z, 1'b0, Z,   1'b0, 1'b0, A_W,  1'b0, Z, 1'b0, 1'b0, I1, 1'b0, DB, 1'b0};

    // Reset state, with a request pending to show stall is forced low
    rst_n = 1'b0;
    applyStimulus(vecs[23]);
    bus.if_req = 1'b1;
    bus1.if_req = 1'b0; bus1.if_addr = Z; bus1.mem_read = 1'b0; bus1.mem_write = 1'b0;
    bus1.mem_addr = Z; bus1.mem_wdata = Z; bus1.mem_bytemode = 1'b0; bus1.mmu_rdata = Z;
    #2;
    checkOutput("reset stall", 32'(bus.stall), 32'd0);
    checkOutput("reset mmu_read", 32'(bus.mmu_read), 32'd0);
    checkOutput("reset mmu_write", 32'(bus.mmu_write), 32'd0);
    checkOutput("reset mmu_addr", bus.mmu_addr, Z);
    checkOutput("reset mmu_wdata", bus.mmu_wdata, Z);
    checkOutput("reset mmu_bytemode", 32'(bus.mmu_bytemode), 32'd0);
    checkOutput("reset if_ready", 32'(bus.if_ready), 32'd0);
    checkOutput("reset mem_ready", 32'(bus.mem_ready), 32'd0);
    checkOutput("reset if_data", bus.if_data, Z);
    checkOutput("reset mem_rdata", bus.mem_rdata, Z);
    @(negedge clk);
    bus.if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d mmu_read", i), 32'(bus.mmu_read), 32'(vecs[i].e_mmu_read));
      checkOutput($sformatf("v%0d mmu_write", i), 32'(bus.mmu_write), 32'(vecs[i].e_mmu_write));
      checkOutput($sformatf("v%0d mmu_addr", i), bus.mmu_addr, vecs[i].e_mmu_addr);
      if (vecs[i].chk_side) begin
        checkOutput($sformatf("v%0d mmu_wdata", i), bus.mmu_wdata, vecs[i].e_mmu_wdata);
        checkOutput($sformatf("v%0d mmu_bytemode", i), 32'(bus.mmu_bytemode), 32'(vecs[i].e_mmu_bytemode));
      end
      checkOutput($sformatf("v%0d if_ready", i), 32'(bus.if_ready), 32'(vecs[i].e_if_ready));
      checkOutput($sformatf("v%0d if_data", i), bus.if_data, vecs[i].e_if_data);
      checkOutput($sformatf("v%0d mem_ready", i), 32'(bus.mem_ready), 32'(vecs[i].e_mem_ready));
      checkOutput($sformatf("v%0d mem_rdata", i), bus.mem_rdata, vecs[i].e_mem_rdata);
      checkOutput($sformatf("v%0d stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
    end

    // Reset in the second ACCESS cycle of a load
    @(negedge clk);
    bus.mem_read  = 1'b1;
    bus.mem_addr  = A_R;
    bus.mmu_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst pre mmu_read", 32'(bus.mmu_read), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst async mmu_read", 32'(bus.mmu_read), 32'd0);
    checkOutput("rst async mmu_write", 32'(bus.mmu_write), 32'd0);
    checkOutput("rst async stall", 32'(bus.stall), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rst hold%0d mem_ready", c), 32'(bus.mem_ready), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    checkOutput("rst release mem_ready", 32'(bus.mem_ready), 32'd0);
    k = 0; reads = 0; seen = 1'b0;
    while (!seen && k < 10) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.mmu_read) reads++;
      if (bus.mem_ready) seen = 1'b1;
    end
    if (!seen) checkOutput("rst retry ready timeout", 32'd0, 32'd1);
    checkOutput("rst retry latency", 32'(k), 32'd3);
    checkOutput("rst retry read cycles", 32'(reads), 32'd2);
    checkOutput("rst retry mem_rdata", bus.mem_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    bus.mem_read = 1'b0;

    // WAIT_CYCLES=1 instance: single load
    @(negedge clk);
    bus1.mem_read  = 1'b1;
    bus1.mem_addr  = 32'h8000_0050;
    bus1.mmu_rdata = 32'h0BAD_F00D;
    #1;
    checkOutput("w1 stall c0", 32'(bus1.stall), 32'd1);
    k = 0; reads = 0; seen = 1'b0;
    while (!seen && k < 10) begin
      @(posedge clk);
      #1;
      k++;
      if (bus1.mmu_read) reads++;
      if (bus1.mem_ready) seen = 1'b1;
    end
    if (!seen) checkOutput("w1 ready timeout", 32'd0, 32'd1);
    checkOutput("w1 latency", 32'(k), 32'd2);
    checkOutput("w1 read cycles", 32'(reads), 32'd1);
    checkOutput("w1 mem_rdata", bus1.mem_rdata, 32'h0BAD_F00D);
    checkOutput("w1 stall resp", 32'(bus1.stall), 32'd0);
    @(negedge clk);
    bus1.mem_read = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly upstream of the MMU. The instruction-fetch (IF) stage and the data-memory (MEM) stage share one MMU port, and this block arbitrates between them.
- Latches the winning request and holds the MMU strobes for a fixed number of wait cycles so the SRAM/UART access completes.
- Captures the read data, returns it to the requester with a one-cycle ready pulse, and drives the pipeline stall.
- Data accesses have priority over fetches.

Parameters:
- WAIT_CYCLES, 2, number of clock cycles the MMU strobes stay asserted per access; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  IF stage requests an instruction fetch; held until if_ready.
- if_addr  in  32  fetch address.
- if_data  out  32  fetched instruction word; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for a fetch.
- mem_read  in  1  MEM stage load request; held until mem_ready.
- mem_write  in  1  MEM stage store request; held until mem_ready.
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- mem_bytemode  in  1  byte access (LB/SB) when 1.
- mem_rdata  out  32  load result; valid while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse for a data access.
- stall  out  1  freezes the pipeline while any request is outstanding and not being acknowledged.
- mmu_read  out  1  to the MMU if_read input.
- mmu_write  out  1  to the MMU if_write input.
- mmu_addr  out  32  to the MMU addr input.
- mmu_wdata  out  32  to the MMU input_data input.
- mmu_bytemode  out  1  to the MMU bytemode input.
- mmu_rdata  in  32  from the MMU output_data output.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wait counter=0.
  - Every output goes to 0: if_data, mem_rdata, if_ready, mem_ready, mmu_read, mmu_write, mmu_addr, mmu_wdata, mmu_bytemode.
  - stall reflects the combinational request terms, forced 0 while rst_n=0.
  - Reset in mid-access drops the MMU strobes immediately, and the interrupted access never produces a ready pulse.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If mem_read or mem_write is 1, grant the data source. Otherwise, if if_req is 1, grant the fetch source. Otherwise stay in IDLE.
  - On grant, register the following, then go to ACCESS with counter=WAIT_CYCLES-1:
    - source;
    - addr (mem_addr or if_addr);
    - wdata;
    - bytemode (mem_bytemode; 0 for fetch);
    - rd/wr (a fetch is always a read).
- mem_read and mem_write both 1 is illegal; it is treated as a write.
- ACCESS:
  - mmu_read/mmu_write/mmu_addr/mmu_wdata/mmu_bytemode are driven from the latched registers and stay stable for all WAIT_CYCLES cycles.
  - Requester inputs are ignored during ACCESS.
  - When counter=0: capture mmu_rdata into the result register of the granted source (reads only; a write leaves the result register unchanged) and go to RESP. Otherwise decrement the counter.
- RESP:
  - All MMU strobes are 0. The ready signal of the granted source is 1 for exactly this cycle.
  - Next state is always IDLE. This bubble lets the requester drop or change its request before the next arbitration.
- Outside ACCESS: mmu_read=mmu_write=0 and mmu_addr holds its last value. if_data and mem_rdata hold their last captured values.
- Latency: a request sampled in IDLE gives ready in cycle WAIT_CYCLES+1 after the sampling edge. With the default this is 3 cycles, and back-to-back accesses have a throughput of one per WAIT_CYCLES+2 cycles.
- stall = ((mem_read|mem_write) & ~mem_ready) | (if_req & ~if_ready).
- Simultaneous IF and MEM requests: data is served first and the fetch is served in the following arbitration. A fetch cannot starve, because MEM issues at most one access per instruction while stalled.
- A request that rises while an access is already running is not sampled until the next IDLE.

Test Plan:
- Single fetch: if_req=1, if_addr=0x80000000, mmu_rdata=0x24010001 during ACCESS. Required: mmu_read=1 for exactly 2 cycles, if_ready pulses in cycle 3, if_data=0x24010001, stall=1 in cycles 0–2 and 0 in cycle 3.
- Byte store: mem_write=1, mem_addr=0x80400007, mem_wdata=0x000000AB, mem_bytemode=1. Required: mmu_write=1, mmu_bytemode=1, mmu_addr=0x80400007, mmu_wdata=0xAB held for 2 cycles, mem_ready pulses once, if_ready stays 0.
- Contention: if_req and mem_read rise in the same cycle. Required: the data access is performed first (mem_ready at cycle 3), IDLE at cycle 4, then the fetch is granted with if_ready at cycle 7.
- Input change during ACCESS: mem_addr changes from 0x80000010 to 0x80000020 in the middle of an access. Required: mmu_addr stays at 0x80000010 until RESP.
- Reset mid-access: rst_n driven to 0 during the second ACCESS cycle. Required: mmu_read/mmu_write fall to 0 without waiting for a clock edge, no ready pulse is produced, and after release with the request still held a fresh full access runs.
- WAIT_CYCLES=1 build: a single load completes with ready in cycle 2.
